// File: rtl/avalon_add_master.sv
// Avalon-MM initiator for the two-register adder slave: writes {b,a} to
// address 0, waits for the slave's result flag, reads the sum from address 1.
module avalon_add_master #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    // command port
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [15:0] i_cmd_a,
    input  logic [15:0] i_cmd_b,
    // response port
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [31:0] o_res_data,
    output logic        o_res_err,
    output logic        o_busy,
    // adder slave interface
    output logic        o_av_cs,
    output logic        o_av_wr,
    output logic        o_av_rd,
    output logic [1:0]  o_av_addr,
    output logic [31:0] o_av_wr_data,
    input  logic [31:0] i_av_rd_data,
    input  logic        i_av_rd_data_vld,
    input  logic        i_av_wait_req
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT_VLD,
        S_READ,
        S_RELEASE,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state,     w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic              r_cs,        w_cs_nxt;
    logic              r_wr,        w_wr_nxt;
    logic              r_rd,        w_rd_nxt;
    logic [1:0]        r_addr,      w_addr_nxt;
    logic [31:0]       r_wr_data,   w_wr_data_nxt;
    logic              r_res_valid, w_res_valid_nxt;
    logic [31:0]       r_res_data,  w_res_data_nxt;
    logic              r_res_err,   w_res_err_nxt;
    logic              w_cmd_ready;

    // Ready is combinational so a slave raising wait_req blocks the very next handshake.
    assign w_cmd_ready = (r_state == S_IDLE) && !i_av_wait_req && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cs        <= 1'b0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_addr      <= 2'd0;
            r_wr_data   <= 32'd0;
            r_res_valid <= 1'b0;
            r_res_data  <= 32'd0;
            r_res_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cs        <= w_cs_nxt;
            r_wr        <= w_wr_nxt;
            r_rd        <= w_rd_nxt;
            r_addr      <= w_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_err   <= w_res_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cs_nxt        = r_cs;
        w_wr_nxt        = r_wr;
        w_rd_nxt        = r_rd;
        w_addr_nxt      = r_addr;
        w_wr_data_nxt   = r_wr_data;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_res_err_nxt   = r_res_err;

        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid && w_cmd_ready) begin
                    w_wr_data_nxt = {i_cmd_b, i_cmd_a};
                    w_cs_nxt      = 1'b1;
                    w_wr_nxt      = 1'b1;
                    w_addr_nxt    = 2'd0;
                    w_state_nxt   = S_WRITE;
                end
            end
            S_WRITE: begin
                // Slave begins its add on the falling edge of this strobe.
                w_cs_nxt    = 1'b0;
                w_wr_nxt    = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_VLD;
            end
            S_WAIT_VLD: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (i_av_rd_data_vld) begin
                    w_cs_nxt    = 1'b1;
                    w_rd_nxt    = 1'b1;
                    w_addr_nxt  = 2'd1;
                    w_state_nxt = S_READ;
                end else if (r_cnt == CNT_LAST) begin
                    w_res_valid_nxt = 1'b1;
                    w_res_err_nxt   = 1'b1;
                    w_res_data_nxt  = 32'd0;
                    w_state_nxt     = S_RESP;
                end
            end
            S_READ: begin
                // Capture now: the slave zeroes rd_data once its flag clears.
                w_res_data_nxt = i_av_rd_data;
                w_cs_nxt       = 1'b0;
                w_rd_nxt       = 1'b0;
                w_cnt_nxt      = '0;
                w_state_nxt    = S_RELEASE;
            end
            S_RELEASE: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (!i_av_rd_data_vld) begin
                    w_res_valid_nxt = 1'b1;
                    w_res_err_nxt   = 1'b0;
                    w_state_nxt     = S_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    // Sum is kept but flagged: the slave never released its flag.
                    w_res_valid_nxt = 1'b1;
                    w_res_err_nxt   = 1'b1;
                    w_state_nxt     = S_RESP;
                end
            end
            S_RESP: begin
                if (i_res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_cs_nxt        = 1'b0;
                w_wr_nxt        = 1'b0;
                w_rd_nxt        = 1'b0;
                w_res_valid_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
        endcase
    end

    assign o_cmd_ready  = w_cmd_ready;
    assign o_res_valid  = r_res_valid;
    assign o_res_data   = r_res_data;
    assign o_res_err    = r_res_err;
    assign o_busy       = (r_state != S_IDLE);
    assign o_av_cs      = r_cs;
    assign o_av_wr      = r_wr;
    assign o_av_rd      = r_rd;
    assign o_av_addr    = r_addr;
    assign o_av_wr_data = r_wr_data;

endmodule

// File: tb/tb_avalon_add_master.sv
// Randomized bench for avalon_add_master with a behavioural adder slave and
// an independent sum/latency reference.
module tb_avalon_add_master;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;
    logic        busy;
    logic        av_cs, av_wr, av_rd;
    logic [1:0]  av_addr;
    logic [31:0] av_wr_data;
    logic [31:0] av_rd_data;
    logic        av_rd_data_vld;
    logic        av_wait_req = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    avalon_add_master #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data), .o_res_err(res_err), .o_busy(busy),
        .o_av_cs(av_cs), .o_av_wr(av_wr), .o_av_rd(av_rd),
        .o_av_addr(av_addr), .o_av_wr_data(av_wr_data),
        .i_av_rd_data(av_rd_data), .i_av_rd_data_vld(av_rd_data_vld),
        .i_av_wait_req(av_wait_req)
    );

    // Adder slave: add on falling edge of write access, clear flag on falling edge of read access.
    bit          slv_en = 1'b1;
    logic [31:0] slv_op = '0;
    logic [31:0] slv_sum = '0;
    logic        slv_vld = 1'b0;
    logic        slv_wacc_d = 1'b0;
    logic        slv_racc_d = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            slv_op <= '0; slv_sum <= '0; slv_vld <= 1'b0;
            slv_wacc_d <= 1'b0; slv_racc_d <= 1'b0;
        end else begin
            slv_wacc_d <= av_cs && av_wr;
            slv_racc_d <= av_cs && av_rd;
            if (av_cs && av_wr && av_addr == 2'd0) slv_op <= av_wr_data;
            if (slv_wacc_d && !(av_cs && av_wr) && slv_en) begin
                slv_sum <= {16'd0, slv_op[15:0]} + {16'd0, slv_op[31:16]};
                slv_vld <= 1'b1;
            end
            if (slv_racc_d && !(av_cs && av_rd)) slv_vld <= 1'b0;
        end
    end
    assign av_rd_data     = slv_vld ? slv_sum : 32'd0;
    assign av_rd_data_vld = slv_vld;

    // Bus monitor: strobe-cycle counts, last address/data, last strobe pulse width.
    int          wr_cnt = 0, rd_cnt = 0;
    int          wr_run = 0, rd_run = 0, wr_last_run = 0, rd_last_run = 0;
    logic [1:0]  wr_addr_l = '0, rd_addr_l = '0;
    logic [31:0] wr_data_l = '0;

    always @(posedge clk) begin
        if (av_cs && av_wr) begin
            wr_cnt <= wr_cnt + 1; wr_run <= wr_run + 1;
            wr_addr_l <= av_addr; wr_data_l <= av_wr_data;
        end else begin
            if (wr_run != 0) wr_last_run <= wr_run;
            wr_run <= 0;
        end
        if (av_cs && av_rd) begin
            rd_cnt <= rd_cnt + 1; rd_run <= rd_run + 1; rd_addr_l <= av_addr;
        end else begin
            if (rd_run != 0) rd_last_run <= rd_run;
            rd_run <= 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a command and return at the negedge following the handshake edge.
    task automatic send_cmd(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        n_chk++;
        if (n >= 50) begin n_fail++; $display("FAIL cmd_accept: cmd_ready never rose"); end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Count negedges until res_valid; cyc = -1 on timeout.
    task automatic wait_res(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (res_valid) begin cyc = i; break; end
        end
        n_chk++;
        if (cyc < 0) begin n_fail++; $display("FAIL res_wait: res_valid never rose"); end
    endtask

    task automatic accept_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_chk++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL res_drop: res_valid=%b expected 0", res_valid); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({cmd_ready, res_valid, res_err, busy, av_cs, av_wr, av_rd} !== 7'd0 ||
            av_addr !== 2'd0 || av_wr_data !== 32'd0 || res_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_vals: rdy=%b rv=%b err=%b busy=%b cs=%b wr=%b rd=%b addr=%h wd=%h rd=%h expected all 0",
                     cmd_ready, res_valid, res_err, busy, av_cs, av_wr, av_rd, av_addr, av_wr_data, res_data);
        end
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: cmd_ready=%b expected 1", cmd_ready); end
    endtask

    task automatic run_sum(input string nm, input logic [15:0] a, input logic [15:0] b, input bit chk_lat);
        int wr0, rd0, cyc;
        logic [31:0] exp_sum;
        exp_sum = 32'(a) + 32'(b);
        wr0 = wr_cnt; rd0 = rd_cnt;
        send_cmd(a, b);
        wait_res(cyc);
        n_chk++;
        if (res_data !== exp_sum || res_err !== 1'b0) begin
            n_fail++; $display("FAIL %s_sum: data=%h err=%b expected %h err=0", nm, res_data, res_err, exp_sum);
        end
        n_chk++;
        if (wr_cnt - wr0 != 1 || rd_cnt - rd0 != 1 || wr_addr_l !== 2'd0 || rd_addr_l !== 2'd1 ||
            wr_data_l !== {b, a}) begin
            n_fail++;
            $display("FAIL %s_bus: writes=%0d reads=%0d waddr=%h raddr=%h wdata=%h expected 1 1 0 1 %h",
                     nm, wr_cnt - wr0, rd_cnt - rd0, wr_addr_l, rd_addr_l, wr_data_l, {b, a});
        end
        n_chk++;
        if (wr_last_run != 1 || rd_last_run != 1) begin
            n_fail++; $display("FAIL %s_strobe: wr width=%0d rd width=%0d expected 1 1", nm, wr_last_run, rd_last_run);
        end
        if (chk_lat) begin
            n_chk++;
            if (cyc != 6) begin n_fail++; $display("FAIL %s_latency: %0d cycles expected 6", nm, cyc); end
        end
        accept_res();
    endtask

    task automatic test_basic();
        run_sum("basic", 16'h0003, 16'h0005, 1'b1);
    endtask

    task automatic test_max();
        run_sum("max", 16'hFFFF, 16'hFFFF, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            run_sum("rand", 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0);
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [15:0] a, b;
        logic [31:0] exp_sum;
        a = 16'($urandom); b = 16'($urandom);
        exp_sum = 32'(a) + 32'(b);
        send_cmd(a, b);
        wait_res(cyc);
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (res_valid !== 1'b1 || res_data !== exp_sum || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_%0d: rv=%b data=%h rdy=%b busy=%b expected 1 %h 0 1", i, res_valid, res_data, cmd_ready, busy, exp_sum);
            end
            @(negedge clk);
        end
        accept_res();
        run_sum("after_hold", 16'h1234, 16'h4321, 1'b1);
    endtask

    task automatic test_timeout();
        int rd0, cyc;
        slv_en = 1'b0;
        rd0 = rd_cnt;
        send_cmd(16'h0001, 16'h0002);
        wait_res(cyc);
        // WAIT_VLD entered one cycle after the handshake, then TMO cycles
        n_chk++;
        if (cyc != TMO + 1) begin n_fail++; $display("FAIL timeout_latency: %0d cycles expected %0d", cyc, TMO + 1); end
        n_chk++;
        if (res_err !== 1'b1 || res_data !== 32'd0) begin
            n_fail++; $display("FAIL timeout_resp: err=%b data=%h expected 1 0", res_err, res_data);
        end
        n_chk++;
        if (rd_cnt != rd0) begin n_fail++; $display("FAIL timeout_noread: reads=%0d expected 0", rd_cnt - rd0); end
        accept_res();
        slv_en = 1'b1;
    endtask

    task automatic test_wait_req();
        int cyc;
        av_wait_req = 1'b1;
        @(negedge clk);
        cmd_a = 16'h00AA; cmd_b = 16'h0055; cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if (cmd_ready !== 1'b0 || av_cs !== 1'b0) begin
                n_fail++; $display("FAIL waitreq_block_%0d: rdy=%b cs=%b expected 0 0", i, cmd_ready, av_cs);
            end
        end
        av_wait_req = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++;
        if (av_cs !== 1'b1 || av_wr !== 1'b1) begin
            n_fail++; $display("FAIL waitreq_write: cs=%b wr=%b expected 1 1", av_cs, av_wr);
        end
        wait_res(cyc);
        n_chk++;
        if (res_data !== 32'h0000_00FF || res_err !== 1'b0) begin
            n_fail++; $display("FAIL waitreq_sum: data=%h err=%b expected 000000ff 0", res_data, res_err);
        end
        accept_res();
    endtask

    task automatic test_reset_mid();
        slv_en = 1'b0;
        send_cmd(16'h0010, 16'h0020);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({res_valid, res_err, busy, av_cs, av_wr, av_rd} !== 6'd0 || av_addr !== 2'd0 ||
            av_wr_data !== 32'd0 || res_data !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_vals: rv=%b err=%b busy=%b cs=%b wr=%b rd=%b addr=%h wd=%h rd=%h expected all 0",
                     res_valid, res_err, busy, av_cs, av_wr, av_rd, av_addr, av_wr_data, res_data);
        end
        reset = 1'b0;
        slv_en = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_noresp: res_valid=%b expected 0", res_valid); end
        run_sum("after_reset", 16'hBEEF, 16'h1111, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_wait_req();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
